// File: rtl/iot_console_controller.sv
// Console keyboard (dev 03) / teleprinter (dev 04) IOT controller.
// Decodes micro-ops, runs rx/tx byte handshakes and raises console irq.
module iot_console_controller #(
  parameter int unsigned TX_DELAY = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot_strobe,
  input  logic        sel_kbd,
  input  logic        sel_tty,
  input  logic [2:0]  op,
  input  logic [11:0] ac_in,
  output logic        skip,
  output logic        ac_clr,
  output logic        ac_or,
  output logic [11:0] ac_out,
  output logic        irq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } tx_state_e;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  kbd_buf_q, kbd_buf_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        kbd_flag_q, kbd_flag_d;
  logic        tty_flag_q, tty_flag_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;

  logic kbd_act, tty_act;
  logic tty_set, tty_clr, tx_load, tx_done;

  assign kbd_act = iot_strobe & sel_kbd;
  // Keyboard wins when both selects are (illegally) high.
  assign tty_act = iot_strobe & sel_tty & ~sel_kbd;

  assign ac_out  = {4'b0, kbd_buf_q};
  assign tx_data = tx_buf_q;
  assign irq     = irq_q;

  always_comb begin
    skip       = 1'b0;
    ac_clr     = 1'b0;
    ac_or      = 1'b0;
    rx_ready   = 1'b0;
    tty_set    = 1'b0;
    tty_clr    = 1'b0;
    tx_load    = 1'b0;
    kbd_flag_d = kbd_flag_q;
    kbd_buf_d  = kbd_buf_q;
    ie_d       = ie_q;
    if (kbd_act) begin
      if (op == 3'd5) begin
        ie_d = ac_in[0];
      end else begin
        skip   = op[0] & kbd_flag_q;
        ac_clr = op[1];
        ac_or  = op[2];
        if (op == 3'd0 || op[1])
          kbd_flag_d = 1'b0;
      end
    end
    if (tty_act) begin
      unique case (op)
        3'd0:       tty_set = 1'b1;
        3'd1:       skip    = tty_flag_q;
        3'd2, 3'd3: tty_clr = 1'b1;
        3'd4:       tx_load = 1'b1;
        3'd5:       skip    = kbd_flag_q | tty_flag_q;
        default: begin
          tty_clr = 1'b1;
          tx_load = 1'b1;
        end
      endcase
    end
    if (!reset && rx_valid && !kbd_flag_q && !kbd_act) begin
      rx_ready   = 1'b1;
      kbd_buf_d  = rx_data;
      kbd_flag_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_buf_d = tx_buf_q;
    tx_valid = 1'b0;
    tx_done  = 1'b0;
    unique case (state_q)
      S_SEND: begin
        tx_valid = ~reset;
        if (tx_ready) begin
          state_d = S_WAIT;
          cnt_d   = 16'(TX_DELAY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) begin
          tx_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (tx_load) begin
          tx_buf_d = ac_in[7:0];
          state_d  = S_SEND;
        end
      end
    endcase
  end

  // Completion set beats a same-cycle clear.
  always_comb begin
    tty_flag_d = tty_flag_q;
    if (tty_clr)
      tty_flag_d = 1'b0;
    if (tty_set || tx_done)
      tty_flag_d = 1'b1;
    irq_d = ie_q & (kbd_flag_q | tty_flag_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      kbd_buf_q  <= 8'd0;
      tx_buf_q   <= 8'd0;
      kbd_flag_q <= 1'b0;
      tty_flag_q <= 1'b0;
      ie_q       <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kbd_buf_q  <= kbd_buf_d;
      tx_buf_q   <= tx_buf_d;
      kbd_flag_q <= kbd_flag_d;
      tty_flag_q <= tty_flag_d;
      ie_q       <= ie_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_iot_console_controller.sv
// Bench for iot_console_controller: directed IOT sequences,
// transmitted bytes checked against a queue of expected bytes.
module tb_iot_console_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        iot_strobe, sel_kbd, sel_tty;
  logic [2:0]  op;
  logic [11:0] ac_in;
  logic        skip, ac_clr, ac_or;
  logic [11:0] ac_out;
  logic        irq;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int n_cmp = 0;
  int n_err = 0;
  int tx_count = 0;
  logic [7:0] exp_q[$];

  iot_console_controller #(.TX_DELAY(4)) dut (
    .clk(clk), .reset(reset), .iot_strobe(iot_strobe),
    .sel_kbd(sel_kbd), .sel_tty(sel_tty), .op(op), .ac_in(ac_in),
    .skip(skip), .ac_clr(ac_clr), .ac_or(ac_or), .ac_out(ac_out),
    .irq(irq), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_count++;
      if (exp_q.size() == 0) begin
        chk("tx_spurious", 0, 1);
      end else begin
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iot_strobe = 1'b0;
    sel_kbd    = 1'b0;
    sel_tty    = 1'b0;
    op         = 3'd0;
  endtask

  task automatic op_chk(input string tag, input bit k, input logic [2:0] o,
                        input logic [11:0] a, input bit esk, input bit eclr,
                        input bit eor);
    iot_strobe = 1'b1;
    sel_kbd    = k;
    sel_tty    = !k;
    op         = o;
    ac_in      = a;
    @(negedge clk);
    chk({tag, "_skip"}, {31'd0, skip}, {31'd0, esk});
    chk({tag, "_clr"}, {31'd0, ac_clr}, {31'd0, eclr});
    chk({tag, "_or"}, {31'd0, ac_or}, {31'd0, eor});
    @(posedge clk);
    #1;
    idle_in();
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    ac_in = '0;
    rx_valid = 1'b0;
    rx_data = '0;
    tx_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_ac_out", {20'd0, ac_out}, 0);
    chk("rst_skip", {31'd0, skip}, 0);
    tick();
    op_chk("rst_ksf", 1, 3'd1, 0, 0, 0, 0);
    op_chk("rst_tsf", 0, 3'd1, 0, 0, 0, 0);

    // keyboard receive and read
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    chk("rx_ready_1", {31'd0, rx_ready}, 1);
    tick();
    @(negedge clk);
    chk("rx_ready_2", {31'd0, rx_ready}, 0);
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rx_irq", {31'd0, irq}, 1);
    tick();
    op_chk("ksf", 1, 3'd1, 0, 1, 0, 0);
    op_chk("krb", 1, 3'd6, 0, 0, 1, 1);
    chk("krb_ac_out", {20'd0, ac_out}, 32'h041);
    op_chk("ksf_after_krb", 1, 3'd1, 0, 0, 0, 0);

    // TLS with delayed accept
    exp_q.push_back(8'hC5);
    op_chk("tls", 0, 3'd6, 12'h0C5, 0, 0, 0);
    @(negedge clk);
    chk("tls_tx_valid", {31'd0, tx_valid}, 1);
    chk("tls_tx_data", {24'd0, tx_data}, 32'hC5);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("tx_held", {31'd0, tx_valid}, 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
    tick();
    tick();
    op_chk("tsf_early", 0, 3'd1, 0, 0, 0, 0);
    op_chk("tsf_set", 0, 3'd1, 0, 1, 0, 0);
    op_chk("tcf", 0, 3'd2, 0, 0, 0, 0);
    op_chk("tsf_clr", 0, 3'd1, 0, 0, 0, 0);

    // loads during WAIT are ignored, TLS still clears the flag
    exp_q.push_back(8'h5A);
    op_chk("tpc", 0, 3'd4, 12'h05A, 0, 0, 0);
    tx_ready = 1'b1;
    tick();
    op_chk("tpc_wait", 0, 3'd4, 12'h077, 0, 0, 0);
    op_chk("tfl", 0, 3'd0, 0, 0, 0, 0);
    op_chk("tls_wait", 0, 3'd7, 12'h033, 0, 0, 0);
    op_chk("tsf_tls_clr", 0, 3'd1, 0, 0, 0, 0);
    op_chk("tsf_done", 0, 3'd1, 0, 1, 0, 0);
    repeat (4) tick();
    chk("tx_count_2", tx_count, 2);

    // interrupt enable and TSK
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    @(negedge clk);
    chk("rx2_ready", {31'd0, rx_ready}, 1);
    tick();
    rx_valid = 1'b0;
    op_chk("tcf2", 0, 3'd2, 0, 0, 0, 0);
    op_chk("kie0", 1, 3'd5, 12'h000, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    chk("irq_ie0", {31'd0, irq}, 0);
    tick();
    op_chk("kie1", 1, 3'd5, 12'h001, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    chk("irq_ie1", {31'd0, irq}, 1);
    tick();
    op_chk("krs", 1, 3'd4, 0, 0, 0, 1);
    chk("krs_ac_out", {20'd0, ac_out}, 32'h012);
    op_chk("kcf", 1, 3'd0, 0, 0, 0, 0);
    op_chk("tfl2", 0, 3'd0, 0, 0, 0, 0);
    op_chk("tsk_tty", 0, 3'd5, 0, 1, 0, 0);
    op_chk("tcf3", 0, 3'd3, 0, 0, 0, 0);
    op_chk("tsk_none", 0, 3'd5, 0, 0, 0, 0);

    // WAIT expiry coincident with TCF
    exp_q.push_back(8'h99);
    op_chk("tpc3", 0, 3'd4, 12'h099, 0, 0, 0);
    tick();
    tick();
    tick();
    tick();
    op_chk("tcf_expiry", 0, 3'd2, 0, 0, 0, 0);
    op_chk("tsf_expiry", 0, 3'd1, 0, 1, 0, 0);
    chk("tx_count_3", tx_count, 3);

    // receive blocked by a keyboard op
    rx_valid   = 1'b1;
    rx_data    = 8'hAB;
    iot_strobe = 1'b1;
    sel_kbd    = 1'b1;
    op         = 3'd0;
    @(negedge clk);
    chk("rx_blocked", {31'd0, rx_ready}, 0);
    tick();
    idle_in();
    @(negedge clk);
    chk("rx_unblocked", {31'd0, rx_ready}, 1);
    tick();
    rx_valid = 1'b0;
    op_chk("ksf2", 1, 3'd1, 0, 1, 0, 0);
    op_chk("kop7", 1, 3'd7, 0, 1, 1, 1);
    chk("kop7_ac_out", {20'd0, ac_out}, 32'h0AB);

    // reset during SEND
    tx_ready = 1'b0;
    op_chk("tfl3", 0, 3'd0, 0, 0, 0, 0);
    op_chk("tpc_abort", 0, 3'd4, 12'h03C, 0, 0, 0);
    @(negedge clk);
    chk("send_tx_valid", {31'd0, tx_valid}, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cycle_tx_valid", {31'd0, tx_valid}, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("post_rst_irq", {31'd0, irq}, 0);
    tick();
    op_chk("post_rst_ksf", 1, 3'd1, 0, 0, 0, 0);
    op_chk("post_rst_tsf", 0, 3'd1, 0, 0, 0, 0);
    op_chk("tfl4", 0, 3'd0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("post_rst_ie", {31'd0, irq}, 1);
    tick();
    op_chk("tcf4", 0, 3'd2, 0, 0, 0, 0);
    exp_q.push_back(8'hE7);
    op_chk("tpc_fresh", 0, 3'd4, 12'h0E7, 0, 0, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("tx_count_4", tx_count, 4);
    tx_ready = 1'b0;
    repeat (6) tick();
    op_chk("tsf_fresh", 0, 3'd1, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iot_console_controller.md
# iot_console_controller

Console terminal controller (keyboard device 03, teleprinter device 04) driven by the IOT decoder's device-select lines. It executes keyboard and teleprinter IOT micro-operations, returns skip and AC-transfer responses to the CPU, and raises the console interrupt request. It also sequences byte-wide handshakes with the external serial receiver and transmitter.

## Interface
- TX_DELAY, default 100: clock cycles from transmitter acceptance to printer flag set (character time); legal range 1..65535.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- iot_strobe  in  1  one-cycle execute pulse for the current IOT instruction.
- sel_kbd  in  1  device 03 selected (IOT603x).
- sel_tty  in  1  device 04 selected (IOT604x).
- op  in  3  IR[2:0] micro-op bits.
- ac_in  in  12  current AC.
- skip  out  1  skip next instruction.
- ac_clr  out  1  CPU clears AC.
- ac_or  out  1  CPU ORs ac_out into AC, after the clear if ac_clr is also set.
- ac_out  out  12  {4'b0, kbd_buf}.
- irq  out  1  interrupt request.
- rx_valid  in  1  receiver has a byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte accepted this cycle.
- tx_valid  out  1  transmit byte offered.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter accepts.

## Operation
- "Active" means iot_strobe=1 and sel_X=1. When not active, skip, ac_clr and ac_or are 0.
- Keyboard ops, sel_kbd, by op value:
  - 0 KCF: clear kbd_flag.
  - 1 KSF: skip if kbd_flag.
  - 2 KCC: ac_clr and clear kbd_flag.
  - 4 KRS: ac_or.
  - 5 KIE: ie <= ac_in[0].
  - 6 KRB: ac_clr, ac_or, clear kbd_flag.
  - 3 and 7: union of the bit meanings (bit0 = skip, bit1 = clear AC and flag, bit2 = read). 7 does skip, clear and read.
- Teleprinter ops, sel_tty, by op value:
  - 0 TFL: set tty_flag.
  - 1 TSF: skip if tty_flag.
  - 2 TCF: clear tty_flag.
  - 4 TPC: load tx_buf <= ac_in[7:0] and start transmit.
  - 5 TSK: skip if kbd_flag or tty_flag.
  - 6 TLS: clear tty_flag, then load and start as for TPC.
  - 3 and 7: treated as 2 and 6.
- Skip is evaluated from flag values before the edge.
- Receive: when kbd_flag=0, rx_valid=1 and there is no active sel_kbd op this cycle, assert rx_ready (combinational), then kbd_buf <= rx_data and kbd_flag <= 1. Otherwise rx_ready=0.
- Transmit FSM states:
  - IDLE: a load op goes to SEND and captures tx_buf.
  - SEND: tx_valid=1, tx_data=tx_buf. When tx_ready=1, go to WAIT with cnt=TX_DELAY-1.
  - WAIT: count down. At cnt=0, set tty_flag and return to IDLE.
- A load op while not IDLE is ignored: tx_buf and cnt are unchanged, and no flag change occurs except TLS's flag clear.
- irq = ie & (kbd_flag | tty_flag), registered.
- Reset values: kbd_flag=0, tty_flag=0, ie=1, kbd_buf=0, tx_buf=0, state IDLE, cnt=0, irq=0, tx_valid=0, rx_ready=0, skip/ac_clr/ac_or=0.

## Timing
- skip, ac_clr, ac_or and ac_out are combinational, valid during the iot_strobe cycle. Flag, ie and buffer updates take effect at the closing edge.
- irq reflects flags one cycle after they change.
- Latency from load op to tx_valid: 1 cycle.
- Latency from tx accept to tty_flag: TX_DELAY cycles. For TX_DELAY=1, the flag sets on the edge after acceptance.
- Simultaneous events:
  - WAIT expiry in the same cycle as TCF/TLS: the set wins, so tty_flag=1.
  - Receive and an active keyboard op in the same cycle: the receive is blocked for that cycle.
  - KRB in the same cycle as rx_valid: the flag clears and the byte is taken on the next cycle.
- Reset mid-transfer aborts the transfer: the FSM goes to IDLE and tx_valid drops in the reset cycle.
- sel_kbd and sel_tty both high is illegal. The keyboard op takes priority and the tty op is ignored.

## Test plan
- Reset, then hold rx_valid=1 with rx_data=8'h41 -> rx_ready pulses once. kbd_flag=1 and irq=1 on the following cycle. KSF -> skip=1. KRB -> ac_clr=1, ac_or=1, ac_out=12'h041, and kbd_flag=0 on the next cycle.
- With TX_DELAY=4, issue TLS with ac_in=12'h0C5 -> tx_valid=1 and tx_data=8'hC5 the next cycle. Hold tx_ready=0 for 3 cycles, then 1. tty_flag sets exactly 4 cycles after acceptance. TSF skips; TCF clears.
- TPC issued during WAIT -> ignored, and only one transfer is observed. TLS during WAIT -> tty_flag is cleared immediately, the original transfer completes, and the flag sets.
- KIE with ac_in[0]=0 while kbd_flag=1 -> irq=0 next cycle. KIE with ac_in[0]=1 -> irq=1. TSK with only tty_flag set -> skip=1.
- WAIT expiry coincident with TCF -> tty_flag=1. rx_valid coincident with KCF -> rx_ready=0 that cycle and 1 the next.
- Assert reset during SEND -> tx_valid=0, flags=0, ie=1 and irq=0 after the edge. The next TPC starts a fresh transfer.
